display_7seg_mux: RTL and testbench



---
 rtl/display_7seg_mux.sv | 152 +++++++++++++++
 tb/tb_display_7seg_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_7seg_mux.sv
// Binary-to-BCD display stage for the stopwatch: converts seconds/tenths with a
// sequential shift-add-3 engine and drives a 4-digit multiplexed common-anode display as SSS.d.
module display_7seg_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] display_seg,
  input  logic [9:0] display_dec_segs,
  output logic [6:0] segmentos,
  output logic       ponto,
  output logic [3:0] anodos,
  output logic       ocupado,
  output logic [1:0] estado_dbg
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  estado_t       estado;
  logic [9:0]    seg_cap;
  logic [9:0]    dec_cap;
  logic          primeiro;
  logic [21:0]   shift_reg;
  logic [3:0]    iter;
  logic [3:0]    dig_c, dig_d, dig_u, dig_t;
  logic          erro;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    indice;
  logic [6:0]    seg_next;
  logic          ponto_next;

  assign estado_dbg = estado;

  // One double-dabble iteration: {bcd[11:0], bin[9:0]}, adjust nibbles then shift.
  function automatic logic [21:0] dabble(input logic [21:0] r);
    logic [21:0] a;
    a = r;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    if (a[17:14] >= 4'd5) a[17:14] = a[17:14] + 4'd3;
    if (a[21:18] >= 4'd5) a[21:18] = a[21:18] + 4'd3;
    return {a[20:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Conversion FSM; inputs are only looked at in OCIOSO, so mid-conversion changes wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      seg_cap   <= '0;
      dec_cap   <= '0;
      primeiro  <= 1'b1;
      shift_reg <= '0;
      iter      <= '0;
      dig_c     <= '0;
      dig_d     <= '0;
      dig_u     <= '0;
      dig_t     <= '0;
      erro      <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      ocupado <= (estado != OCIOSO);
      case (estado)
        OCIOSO: begin
          if (primeiro || ({display_seg, display_dec_segs} != {seg_cap, dec_cap})) begin
            seg_cap   <= display_seg;
            dec_cap   <= display_dec_segs;
            primeiro  <= 1'b0;
            shift_reg <= {12'd0, display_seg};
            iter      <= '0;
            estado    <= CONVERTE;
          end
        end
        CONVERTE: begin
          shift_reg <= dabble(shift_reg);
          iter      <= iter + 4'd1;
          if (iter == 4'd9) estado <= ATUALIZA;
        end
        ATUALIZA: begin
          dig_c  <= shift_reg[21:18];
          dig_d  <= shift_reg[17:14];
          dig_u  <= shift_reg[13:10];
          dig_t  <= dec_cap[3:0];
          erro   <= (seg_cap > 10'd999) || (dec_cap > 10'd9);
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  always_comb begin
    seg_next   = 7'h7F;
    ponto_next = 1'b1;
    if (erro) begin
      seg_next = 7'h3F;
    end else begin
      case (indice)
        2'd0: seg_next = seg7(dig_t);
        2'd1: begin
          seg_next   = seg7(dig_u);
          ponto_next = 1'b0;
        end
        2'd2: if (!(dig_d == 4'd0 && dig_c == 4'd0)) seg_next = seg7(dig_d);
        default: if (dig_c != 4'd0) seg_next = seg7(dig_c);
      endcase
    end
  end

  // Outputs follow the index registered before the edge, so each anode still dwells REFRESH_DIV cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt   <= '0;
      indice    <= '0;
      anodos    <= 4'hF;
      segmentos <= 7'h7F;
      ponto     <= 1'b1;
    end else begin
      if (ref_cnt == REF_MAX) begin
        ref_cnt <= '0;
        indice  <= indice + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CW'(1);
      end
      anodos    <= ~(4'b0001 << indice);
      segmentos <= seg_next;
      ponto     <= ponto_next;
    end
  end

endmodule

// File: tb/tb_display_7seg_mux.sv
// Self-checking bench for display_7seg_mux: directed and random seconds/tenths pairs
// compared against a decimal-arithmetic model of the SSS.d display.
module tb_display_7seg_mux;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] display_seg = '0;
  logic [9:0] display_dec_segs = '0;
  logic [6:0] segmentos;
  logic       ponto;
  logic [3:0] anodos;
  logic       ocupado;
  logic [1:0] estado_dbg;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int shown_sec = 0;
  int shown_ten = 0;
  int cur_sec = 0;
  int cur_ten = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  display_7seg_mux #(.REFRESH_DIV(DIV)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .display_seg      (display_seg),
    .display_dec_segs (display_dec_segs),
    .segmentos        (segmentos),
    .ponto            (ponto),
    .anodos           (anodos),
    .ocupado          (ocupado),
    .estado_dbg       (estado_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int sec, input int ten, input int idx);
    if (sec > 999 || ten > 9) return 7'h3F;
    case (idx)
      0: return seg_tab[ten];
      1: return seg_tab[sec % 10];
      2: return (sec < 10) ? 7'h7F : seg_tab[(sec / 10) % 10];
      default: return (sec < 100) ? 7'h7F : seg_tab[sec / 100];
    endcase
  endfunction

  function automatic logic exp_ponto(input int sec, input int ten, input int idx);
    if (sec > 999 || ten > 9) return 1'b1;
    return (idx == 1) ? 1'b0 : 1'b1;
  endfunction

  // One clock: sample #1 after the edge and check the multiplexed outputs.
  task automatic tick();
    int idx;
    logic [3:0] one_hot;
    @(posedge clock);
    #1;
    n++;
    idx = ((n - 1) / DIV) % 4;
    one_hot = 4'b0001 << idx;
    chk("anodos", {28'd0, anodos}, {28'd0, ~one_hot});
    chk("segmentos", {25'd0, segmentos}, {25'd0, exp_seg(shown_sec, shown_ten, idx)});
    chk("ponto", {31'd0, ponto}, {31'd0, exp_ponto(shown_sec, shown_ten, idx)});
  endtask

  task automatic drive(input int sec, input int ten);
    display_seg      = 10'(sec);
    display_dec_segs = 10'(ten);
    cur_sec = sec;
    cur_ten = ten;
  endtask

  // DUT idle with freshly changed inputs: next edge samples, digits visible 12 edges later.
  task automatic expect_conversion(input int sec, input int ten);
    tick();
    chk("ocupado_idle", {31'd0, ocupado}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("ocupado_busy", {31'd0, ocupado}, 32'd1);
    end
    shown_sec = sec;
    shown_ten = ten;
    tick();
    chk("ocupado_done", {31'd0, ocupado}, 32'd0);
  endtask

  task automatic apply(input int sec, input int ten);
    drive(sec, ten);
    expect_conversion(sec, ten);
    for (int i = 0; i < 4 * DIV; i++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_anodos"}, {28'd0, anodos}, 32'hF);
    chk({tag, "_seg"}, {25'd0, segmentos}, 32'h7F);
    chk({tag, "_ponto"}, {31'd0, ponto}, 32'd1);
    chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
  endtask

  initial begin
    int s;
    int t;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    expect_conversion(0, 0);
    for (int i = 0; i < 4 * DIV; i++) tick();

    apply(123, 7);
    apply(5, 0);
    apply(40, 9);
    apply(999, 9);
    apply(0, 0);
    apply(1000, 0);
    apply(12, 10);
    apply(12, 3);
    apply(100, 0);

    // Input change while converting: old pair shown first, new one picked up afterwards.
    drive(200, 1);
    tick();
    chk("mid_idle", {31'd0, ocupado}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_busy", {31'd0, ocupado}, 32'd1);
    end
    drive(201, 2);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_busy", {31'd0, ocupado}, 32'd1);
    end
    shown_sec = 200;
    shown_ten = 1;
    expect_conversion(201, 2);
    for (int i = 0; i < 4 * DIV; i++) tick();

    for (int r = 0; r < 10; r++) begin
      do begin
        s = (($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 999));
        t = (($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
      end while (s == cur_sec && t == cur_ten);
      apply(s, t);
    end

    // Asynchronous reset in the middle of a conversion.
    drive(777, 7);
    tick();
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    shown_sec = 0;
    shown_ten = 0;
    n = 0;
    @(negedge clock);
    reset_n = 1'b1;
    expect_conversion(777, 7);
    for (int i = 0; i < 4 * DIV; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
